mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while an instruction fetch waits.
REQ-002 SHALL have port CLK, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port nRST, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port iREN, input, 1: instruction read request.
REQ-005 SHALL have port iaddr, input, 32: instruction word address.
REQ-006 SHALL have port ihit, output, 1: one-cycle pulse, instruction read done.
REQ-007 SHALL have port iload, output, 32: instruction data, valid while ihit=1.
REQ-008 SHALL have port dREN, input, 1: data read request.
REQ-009 SHALL have port dWEN, input, 1: data write request.
REQ-010 SHALL have port daddr, input, 32: data address.
REQ-011 SHALL have port dstore, input, 32: write data.
REQ-012 SHALL have port dhit, output, 1: one-cycle pulse, data access done.
REQ-013 SHALL have port dload, output, 32: read data, valid while dhit=1.
REQ-014 SHALL have ports ramREN, output, 1 and ramWEN, output, 1: RAM strobes.
REQ-015 SHALL have ports ramaddr, output, 32 and ramstore, output, 32: RAM address and write data.
REQ-016 SHALL have port ramload, input, 32: RAM read data.
REQ-017 SHALL have port ramstate, input, ramstate_t (2 bits): FREE, BUSY, ACCESS, ERROR.
REQ-018 SHALL have port memerr, output, 1: sticky RAM error flag.

Function
REQ-019 SHALL implement FSM with states IDLE, IGRANT, DGRANT; state registered.
REQ-020 IDLE: (dREN|dWEN) and (!iREN or scnt<STARVE_MAX) -> DGRANT; else iREN -> IGRANT; else stay; RAM strobes low.
REQ-021 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr, combinationally.
REQ-022 DGRANT: ramWEN=dWEN, ramREN=dREN&!dWEN (write wins), ramaddr=daddr, ramstore=dstore.
REQ-023 Granted state with ramstate=ACCESS: pulse hit of granted side same cycle, load=ramload, next state IDLE.
REQ-024 ramstate BUSY or FREE in a grant state: hold state, hits low.
REQ-025 ramstate=ERROR in a grant state: set memerr, no hit, return to IDLE (request retried).
REQ-026 Granted requester dropping its request before ACCESS: next state IDLE, no hit; RAM strobes follow request combinationally.
REQ-027 Starvation counter scnt (width clog2(STARVE_MAX+1)): +1 per completed data access with iREN=1, saturates at STARVE_MAX, cleared on ihit or when iREN=0.
REQ-028 Every access costs at least 2 cycles (grant + IDLE bubble); zero-wait RAM gives one hit per 2 cycles.
REQ-029 iload/dload SHALL read 0 when the matching hit is low.

Reset
REQ-030 nRST low SHALL asynchronously force state=IDLE, scnt=0, memerr=0.
REQ-031 During reset all outputs SHALL be 0: ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, memerr.
REQ-032 Reset asserted mid-grant SHALL abort the access with no hit pulse; first request after release is arbitrated from IDLE.

Structure
REQ-033 ramstate_t and new arb_state_t (IDLE, IGRANT, DGRANT) SHALL live in cpu_types_pkg; STARVE_MAX stays a module parameter.
REQ-034 No sub-module; FSM, counter and output muxing SHALL be in mem_arbiter.

Verification
REQ-035 iREN=1, iaddr=0x40, ramstate ACCESS on 3rd grant cycle, ramload=0x8C220004 -> ihit pulse that cycle, iload=0x8C220004, back to IDLE.
REQ-036 iREN=1 and dREN=1 same cycle, daddr=0x100 -> DGRANT first, dhit, then IGRANT, ihit.
REQ-037 dREN held continuously with iREN=1, STARVE_MAX=4 -> exactly 4 dhit pulses, then IGRANT and ihit; scnt=0 after.
REQ-038 dREN=1 and dWEN=1, dstore=0xDEADBEEF, daddr=0x200 -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-039 ramstate=ERROR in DGRANT -> memerr=1 held, no dhit, retry; ACCESS next grant -> dhit.
REQ-040 nRST low during IGRANT with ramstate BUSY -> all outputs 0 immediately, no ihit; after release iREN re-granted.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state and memory arbiter FSM encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data
// priority bounded by a starvation counter so fetches always make progress.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        memerr
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_t    state, nxt_state;
  logic [SW-1:0] scnt;
  logic          dreq;
  logic          set_err;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nxt_state;
  end

  // Outputs are zero in IDLE, so reset (which forces IDLE) zeroes them too.
  always_comb begin
    nxt_state = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && (!iREN || scnt < SMAX)) nxt_state = DGRANT;
        else if (iREN)                      nxt_state = IGRANT;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) nxt_state = IDLE;
        else begin
          case (ramstate)
            ACCESS: begin
              ihit      = 1'b1;
              iload     = ramload;
              nxt_state = IDLE;
            end
            ERROR: begin
              set_err   = 1'b1;
              nxt_state = IDLE;
            end
            default: ;
          endcase
        end
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) nxt_state = IDLE;
        else begin
          case (ramstate)
            ACCESS: begin
              dhit      = 1'b1;
              dload     = ramload;
              nxt_state = IDLE;
            end
            ERROR: begin
              set_err   = 1'b1;
              nxt_state = IDLE;
            end
            default: ;
          endcase
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Counts data wins while a fetch is pending; any fetch completion or a
  // fetch that is no longer waiting restarts the window.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          scnt <= '0;
    else if (!iREN || ihit)             scnt <= '0;
    else if (dhit && scnt != SMAX)      scnt <= scnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        memerr <= 1'b0;
    else if (set_err) memerr <= 1'b1;
  end

endmodule
